// File: rtl/btn_event.sv
// btn_event: turns a debounced, clock-synchronous button level into single-cycle
// press / release / long-press / auto-repeat events plus a held level.
// Optional feature macro: BTN_AUTOREPEAT_EN enables repeat_o in the held state.
// Without it, repeat_o stays 0 and the ms counter is frozen while held.

module btn_event #(
    parameter int unsigned CLOCK_FREQ = 100000000,
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned REPEAT_MS  = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic signal_i,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    localparam int unsigned TICKS = CLOCK_FREQ / 1000;
    // Prescaler only has to reach TICKS-1.
    localparam int unsigned PW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICKS - 1);
    localparam logic [15:0] LONG_LAST = 16'(LONG_MS - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [15:0] REPEAT_LAST = 16'(REPEAT_MS - 1);
`endif

    // Elaboration-time parameter legality checks.
    if (TICKS < 1) begin : g_bad_clock_freq
        $error("btn_event: CLOCK_FREQ must be at least 1000");
    end
    if (LONG_MS < 1 || LONG_MS > 65535) begin : g_bad_long_ms
        $error("btn_event: LONG_MS out of range 1..65535");
    end
    if (REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_repeat_ms
        $error("btn_event: REPEAT_MS out of range 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t        state;
    logic          prev;
    logic [PW-1:0] presc;
    logic [15:0]   ms_cnt;

    logic rise;
    logic fall;
    logic ms_tick;

    assign rise    = signal_i & ~prev;
    assign fall    = ~signal_i & prev;
    assign ms_tick = (presc == TICK_LAST);

    // Edge tracking, ms timebase and event FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prev      <= 1'b0;
            presc     <= '0;
            ms_cnt    <= '0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            prev      <= signal_i;
            // Pulses are high for one cycle only unless re-asserted below.
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            repeat_o  <= 1'b0;

            case (state)
                S_IDLE: begin
                    held_o <= 1'b0;
                    presc  <= '0;
                    ms_cnt <= '0;
                    if (rise) begin
                        press_o <= 1'b1;
                        state   <= S_PRESS;
                    end
                end

                S_PRESS: begin
                    held_o <= 1'b0;
                    if (fall) begin
                        // Release beats a coincident long threshold.
                        release_o <= 1'b1;
                        state     <= S_IDLE;
                        presc     <= '0;
                        ms_cnt    <= '0;
                    end else if (ms_tick && ms_cnt == LONG_LAST) begin
                        long_o <= 1'b1;
                        held_o <= 1'b1;
                        state  <= S_HELD;
                        presc  <= '0;
                        ms_cnt <= '0;
                    end else if (ms_tick) begin
                        presc  <= '0;
                        ms_cnt <= ms_cnt + 16'd1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end

                S_HELD: begin
                    held_o <= 1'b1;
                    if (fall) begin
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                        state     <= S_IDLE;
                        presc     <= '0;
                        ms_cnt    <= '0;
`ifdef BTN_AUTOREPEAT_EN
                    end else if (ms_tick && ms_cnt == REPEAT_LAST) begin
                        repeat_o <= 1'b1;
                        presc    <= '0;
                        ms_cnt   <= '0;
                    end else if (ms_tick) begin
                        presc  <= '0;
                        ms_cnt <= ms_cnt + 16'd1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
`else
                    end
`endif
                end

                default: begin
                    // Illegal encoding: fall back to idle quietly.
                    state  <= S_IDLE;
                    held_o <= 1'b0;
                    presc  <= '0;
                    ms_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event.sv
// Self-checking bench for btn_event at CLOCK_FREQ=10000, LONG_MS=3, REPEAT_MS=2.
// Honours BTN_AUTOREPEAT_EN the same way as the design.

module tb_btn_event;

    localparam int unsigned CLOCK_FREQ = 10000;
    localparam int unsigned LONG_MS    = 3;
    localparam int unsigned REPEAT_MS  = 2;
    localparam int TICKS    = 10;
    localparam int LONG_CYC = 30;
    localparam int REP_CYC  = 20;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic signal_i;
    logic press_o;
    logic release_o;
    logic long_o;
    logic repeat_o;
    logic held_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int held_cnt = 0;
    int press_q[$];
    int rel_q[$];
    int long_q[$];
    int rep_q[$];

    btn_event #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .signal_i (signal_i),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o),
        .repeat_o (repeat_o),
        .held_o   (held_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        press_q.delete();
        rel_q.delete();
        long_q.delete();
        rep_q.delete();
        held_cnt = 0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: press age in cycles decides long/repeat timing.
    bit m_prev = 1'b0;
    bit m_active = 1'b0;
    bit m_long = 1'b0;
    int m_age = 0;
    logic [4:0] exp_v = '0;
    logic [4:0] got_v;

    initial begin
        bit s;
        bit e_p, e_r, e_l, e_rp, e_h;
        e_h = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            e_p = 1'b0; e_r = 1'b0; e_l = 1'b0; e_rp = 1'b0;
            if (!rst_n) begin
                m_prev = 1'b0; m_active = 1'b0; m_long = 1'b0; m_age = 0;
                e_h = 1'b0;
            end else begin
                s = signal_i;
                if (m_active) begin
                    if (!s) begin
                        e_r = 1'b1;
                        e_h = 1'b0;
                        m_active = 1'b0;
                    end else begin
                        m_age++;
                        if (!m_long) begin
                            if (m_age == LONG_CYC) begin
                                e_l = 1'b1;
                                e_h = 1'b1;
                                m_long = 1'b1;
                            end
                        end else if (REPEAT_ON && ((m_age - LONG_CYC) % REP_CYC == 0)) begin
                            e_rp = 1'b1;
                        end
                    end
                end else if (s && !m_prev) begin
                    e_p = 1'b1;
                    m_active = 1'b1;
                    m_age = 0;
                    m_long = 1'b0;
                end
                m_prev = s;
            end
            exp_v = {e_p, e_r, e_l, e_rp, e_h};
            #1;
            got_v = {press_o, release_o, long_o, repeat_o, held_o};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL cycle %0d press/release/long/repeat/held: got %b expected %b",
                         cyc, got_v, exp_v);
            end
            if (press_o === 1'b1) press_q.push_back(cyc);
            if (release_o === 1'b1) rel_q.push_back(cyc);
            if (long_o === 1'b1) long_q.push_back(cyc);
            if (repeat_o === 1'b1) rep_q.push_back(cyc);
            if (held_o === 1'b1) held_cnt++;
        end
    end

    initial begin
        int c;
        rst_n = 1'b0;
        signal_i = 1'b0;

        // 1. Reset and idle
        wait_neg(5);
        check("reset_outputs", {press_o, release_o, long_o, repeat_o, held_o}, 0);
        rst_n = 1'b1;
        clear_log();
        wait_neg(100);
        check("idle_events", press_q.size() + rel_q.size() + long_q.size() + rep_q.size(), 0);
        check("idle_held", held_cnt, 0);

        // 2. Short press
        clear_log();
        signal_i = 1'b1;
        wait_neg(15);
        signal_i = 1'b0;
        wait_neg(10);
        check("short_press_cnt", press_q.size(), 1);
        check("short_rel_cnt", rel_q.size(), 1);
        check("short_rel_gap",
              (press_q.size() == 1 && rel_q.size() == 1) ? rel_q[0] - press_q[0] : -1, 15);
        check("short_no_long", long_q.size(), 0);
        check("short_held", held_cnt, 0);

        // 3. Long press held 80 cycles
        clear_log();
        signal_i = 1'b1;
        wait_neg(80);
        signal_i = 1'b0;
        wait_neg(10);
        check("long_cnt", long_q.size(), 1);
        check("long_gap",
              (press_q.size() == 1 && long_q.size() == 1) ? long_q[0] - press_q[0] : -1, 30);
        check("long_rel_gap",
              (press_q.size() == 1 && rel_q.size() == 1) ? rel_q[0] - press_q[0] : -1, 80);
        check("long_held_cycles", held_cnt, 50);
        if (REPEAT_ON) begin
            check("repeat_cnt", rep_q.size(), 2);
            check("repeat_gap1",
                  (rep_q.size() == 2 && long_q.size() == 1) ? rep_q[0] - long_q[0] : -1, 20);
            check("repeat_gap2",
                  (rep_q.size() == 2 && long_q.size() == 1) ? rep_q[1] - long_q[0] : -1, 40);
        end else begin
            check("repeat_none", rep_q.size(), 0);
        end

        // 4. Release exactly on the long threshold
        clear_log();
        signal_i = 1'b1;
        wait_neg(30);
        signal_i = 1'b0;
        wait_neg(40);
        check("thr_rel_gap",
              (press_q.size() == 1 && rel_q.size() == 1) ? rel_q[0] - press_q[0] : -1, 30);
        check("thr_no_long", long_q.size(), 0);
        check("thr_no_held", held_cnt, 0);

        // 5. Reset while held, input still high on release of reset
        signal_i = 1'b1;
        wait_neg(40);
        check("pre_reset_held", held_o, 1);
        clear_log();
        rst_n = 1'b0;
        #1;
        check("async_clear", {press_o, release_o, long_o, repeat_o, held_o}, 0);
        wait_neg(3);
        check("reset_no_release", rel_q.size(), 0);
        rst_n = 1'b1;
        c = cyc;
        wait_neg(3);
        check("post_reset_press_cnt", press_q.size(), 1);
        check("post_reset_press_cyc", (press_q.size() == 1) ? press_q[0] : -1, c + 1);
        signal_i = 1'b0;
        wait_neg(10);
        check("post_reset_release", rel_q.size(), 1);

        // 6. Back-to-back presses with a one-cycle gap
        clear_log();
        signal_i = 1'b1;
        wait_neg(12);
        signal_i = 1'b0;
        wait_neg(1);
        signal_i = 1'b1;
        wait_neg(12);
        signal_i = 1'b0;
        wait_neg(10);
        check("b2b_press_cnt", press_q.size(), 2);
        check("b2b_rel_cnt", rel_q.size(), 2);
        check("b2b_rel1",
              (press_q.size() == 2 && rel_q.size() == 2) ? rel_q[0] - press_q[0] : -1, 12);
        check("b2b_press2",
              (press_q.size() == 2) ? press_q[1] - press_q[0] : -1, 13);
        check("b2b_rel2",
              (press_q.size() == 2 && rel_q.size() == 2) ? rel_q[1] - press_q[0] : -1, 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
